shift_unit: RTL and testbench

- Multi-cycle shift execution unit for the MIPS datapath.
- Sits between decode/register-read (upstream) and register writeback (downstream).
- Executes SLL/SRL/SRA/SLLV/SRLV/SRAV iteratively, STEP bit positions per cycle.
- Uses valid/ready handshakes on both sides so the core can stall on it.

---
 rtl/shift_unit.sv | 83 ++++++++
 tb/tb_shift_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// shift_unit: iterative MIPS shifter (SLL/SRL/SRA and V variants), STEP bits per cycle, valid/ready on both sides
module shift_unit #(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [4:0]  rd_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  wr_addr,
   output logic        illegal,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [4:0] STEP_W = 5'(STEP);
   state_t      r_state, w_next;
   logic [31:0] r_work;
   logic [4:0]  r_count;
   logic [4:0]  r_wr_addr;
   logic        r_left, r_arith, r_illegal;
   logic        w_accept, w_legal, w_left, w_arith, w_unused;
   logic [4:0]  w_amount, w_k, w_count_next;
   logic [31:0] w_sra, w_shifted;
   assign w_accept     = in_valid && r_state == IDLE;
   assign w_legal      = funct[5:3] == 3'b000 && funct[1:0] != 2'b01;
   assign w_left       = funct[1:0] == 2'b00;
   assign w_arith      = funct[1:0] == 2'b11;
   assign w_amount     = funct[2] ? rs_data[4:0] : shamt;
   assign w_unused     = ^rs_data[31:5];
   assign w_k          = r_count < STEP_W ? r_count : STEP_W;
   assign w_count_next = r_count - w_k;
   // bit 31 never changes under an arithmetic shift, so it always holds the original sign
   assign w_sra        = $signed(r_work) >>> w_k;
   assign w_shifted    = r_left ? r_work << w_k : r_arith ? w_sra : r_work >> w_k;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next = (!w_legal || w_amount == 5'd0) ? DONE : SHIFT;
         SHIFT:   if (w_count_next == 5'd0) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_work    <= '0;
         r_count   <= '0;
         r_wr_addr <= '0;
         r_left    <= 1'b0;
         r_arith   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_work    <= rt_data;
         r_count   <= w_legal ? w_amount : 5'd0;
         r_wr_addr <= rd_addr;
         r_left    <= w_left;
         r_arith   <= w_arith;
         r_illegal <= !w_legal;
      end else if (r_state == SHIFT) begin
         r_work    <= w_shifted;
         r_count   <= w_count_next;
      end else if (r_state == DONE && out_ready) begin
         r_illegal <= 1'b0;
      end
   end
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign busy      = r_state != IDLE;
   assign result    = r_work;
   assign wr_addr   = r_wr_addr;
   assign illegal   = r_illegal;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: STEP=1 and STEP=4 units driven in lockstep, checked against vectors and an arithmetic model
`timescale 1ns/1ps
module tb_shift_unit;
   logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [5:0]  funct = '0;
   logic [4:0]  shamt = '0, rd_addr = '0;
   logic [31:0] rs_data = '0, rt_data = '0;
   logic        in_ready1, out_valid1, illegal1, busy1;
   logic        in_ready4, out_valid4, illegal4, busy4;
   logic [31:0] result1, result4;
   logic [4:0]  wr_addr1, wr_addr4;
   int          n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   shift_unit #(.STEP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1), .funct(funct),
      .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr), .out_valid(out_valid1),
      .out_ready(out_ready), .result(result1), .wr_addr(wr_addr1), .illegal(illegal1), .busy(busy1));
   shift_unit #(.STEP(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4), .funct(funct),
      .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr), .out_valid(out_valid4),
      .out_ready(out_ready), .result(result4), .wr_addr(wr_addr4), .illegal(illegal4), .busy(busy4));

   typedef struct {
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] rs, rt;
      logic [4:0]  rd;
      logic [31:0] res;
      int          lat1, lat4;
      logic        ill;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   // reference: plain shift operators on the whole amount, latency from ceil division
   task automatic model(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs, input logic [31:0] rt,
                        input int step, output logic [31:0] res, output int lat, output logic ill);
      int amt;
      logic signed [31:0] srt;
      srt = rt;
      ill = 1'b0;
      amt = (f == 6'd4 || f == 6'd6 || f == 6'd7) ? int'(rs % 32) : int'(sa);
      case (f)
         6'd0, 6'd4: res = rt << amt;
         6'd2, 6'd6: res = rt >> amt;
         6'd3, 6'd7: res = srt >>> amt;
         default: begin res = rt; ill = 1'b1; amt = 0; end
      endcase
      lat = 1 + (amt + step - 1) / step;
   endtask

   task automatic collect(input string nm, input logic [31:0] er, input logic [4:0] ea, input logic ei,
                          input int l1, input int l4);
      int c = 1, g1 = 0, g4 = 0;
      while ((g1 == 0 || g4 == 0) && c <= 60) begin
         if (out_valid1 && g1 == 0) g1 = c;
         if (out_valid4 && g4 == 0) g4 = c;
         if (g1 == 0 || g4 == 0) begin @(posedge clk); #1; c++; end
      end
      chk({nm, " lat1"}, g1, l1);
      chk({nm, " lat4"}, g4, l4);
      chk({nm, " res1"}, result1, er);
      chk({nm, " res4"}, result4, er);
      chk({nm, " wr1"}, {27'd0, wr_addr1}, {27'd0, ea});
      chk({nm, " wr4"}, {27'd0, wr_addr4}, {27'd0, ea});
      chk({nm, " ill1"}, {31'd0, illegal1}, {31'd0, ei});
      chk({nm, " ill4"}, {31'd0, illegal4}, {31'd0, ei});
      chk({nm, " rdy_busy"}, {in_ready1, busy1, in_ready4, busy4}, 4'b0101);
   endtask

   task automatic release_out(input string nm);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " after_hs"}, {out_valid1, illegal1, in_ready1, busy1, out_valid4, illegal4, in_ready4, busy4},
          8'b0010_0010);
   endtask

   task automatic issue(input string nm, input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] er, input logic ei,
                        input int l1, input int l4);
      funct = f; shamt = sa; rs_data = rs; rt_data = rt; rd_addr = rd; in_valid = 1'b1;
      chk({nm, " in_ready"}, {in_ready1, in_ready4}, 2'b11);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(nm, er, rd, ei, l1, l4);
   endtask

   vec_t vecs[$];

   initial begin
      logic [31:0] r1, r4, hold_res;
      logic [4:0]  hold_wr;
      logic [5:0]  f;
      int          lt1, lt4;
      logic        il1, il4;
      logic [5:0]  legal_f[6];
      legal_f = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
      vecs.push_back('{6'b000010, 5'd3,  32'h0,        32'h10,       5'd16, 32'h00000002,  4,  2, 1'b0});
      vecs.push_back('{6'b000011, 5'd4,  32'h0,        32'h80000000, 5'd5,  32'hF8000000,  5,  2, 1'b0});
      vecs.push_back('{6'b000110, 5'd9,  32'hFFFFFFE3, 32'h30,       5'd7,  32'h00000006,  4,  2, 1'b0});
      vecs.push_back('{6'b000000, 5'd0,  32'h0,        32'h1234,     5'd1,  32'h00001234,  1,  1, 1'b0});
      vecs.push_back('{6'b100000, 5'd7,  32'h0,        32'hABCD,     5'd3,  32'h0000ABCD,  1,  1, 1'b1});
      vecs.push_back('{6'b000000, 5'd31, 32'h0,        32'h1,        5'd31, 32'h80000000, 32,  9, 1'b0});
      vecs.push_back('{6'b000111, 5'd0,  32'h1F,       32'h80000000, 5'd2,  32'hFFFFFFFF, 32,  9, 1'b0});
      vecs.push_back('{6'b000100, 5'd1,  32'h25,       32'h3,        5'd8,  32'h00000060,  6,  3, 1'b0});
      vecs.push_back('{6'b000011, 5'd8,  32'h0,        32'h7F000000, 5'd9,  32'h007F0000,  9,  3, 1'b0});

      #1;
      chk("reset1", {in_ready1, out_valid1, busy1, illegal1, wr_addr1, result1}, {4'b1000, 5'd0, 32'd0});
      chk("reset4", {in_ready4, out_valid4, busy4, illegal4, wr_addr4, result4}, {4'b1000, 5'd0, 32'd0});
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         issue($sformatf("vec%0d", i), vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt, vecs[i].rd,
               vecs[i].res, vecs[i].ill, vecs[i].lat1, vecs[i].lat4);
         release_out($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
         rs_data = $urandom; rt_data = $urandom; shamt = 5'($urandom); rd_addr = 5'($urandom);
         model(f, shamt, rs_data, rt_data, 1, r1, lt1, il1);
         model(f, shamt, rs_data, rt_data, 4, r4, lt4, il4);
         issue($sformatf("rnd%0d", i), f, shamt, rs_data, rt_data, rd_addr, r1, il1, lt1, lt4);
         release_out($sformatf("rnd%0d", i));
      end

      // backpressure: held result while new operands churn, pending op taken one edge after IDLE
      issue("bp", 6'd0, 5'd2, 32'h0, 32'h5, 5'd9, 32'h14, 1'b0, 3, 2);
      hold_res = result1; hold_wr = wr_addr1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         funct = 6'd2; shamt = 5'd1; rt_data = $urandom; rd_addr = 5'($urandom); rs_data = $urandom;
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", i), {out_valid1, in_ready1, out_valid4, in_ready4, wr_addr1, result1},
             {4'b1010, hold_wr, hold_res});
      end
      rt_data = 32'h8; rd_addr = 5'd4;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_idle", {out_valid1, in_ready1, busy1, out_valid4, in_ready4, busy4}, 6'b010_010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept", {busy1, in_ready1, busy4, in_ready4}, 4'b1010);
      collect("bp_pending", 32'h4, 5'd4, 1'b0, 2, 2);
      release_out("bp_pending");

      // async reset in the middle of a long shift
      funct = 6'd0; shamt = 5'd20; rt_data = 32'h1; rd_addr = 5'd12; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #0.5;
      chk("rst_mid1", {in_ready1, out_valid1, busy1, illegal1, result1}, {4'b1000, 32'd0});
      chk("rst_mid4", {in_ready4, out_valid4, busy4, illegal4, result4}, {4'b1000, 32'd0});
      #0.5 reset_n = 1'b1;
      @(negedge clk);
      issue("post_rst", 6'b000010, 5'd3, 32'h0, 32'h10, 5'd16, 32'h2, 1'b0, 4, 2);
      release_out("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
